// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage array: true-LRU replacement, registered
// one-cycle lookup, victim reporting and a sequenced invalidate-all sweep.
module dcache_sram_nway #(
    parameter  int unsigned SETS   = 16,
    parameter  int unsigned WAYS   = 2,
    parameter  int unsigned TAG_W  = 23,
    parameter  int unsigned LINE_W = 256,
    localparam int unsigned IDX_W  = $clog2(SETS),
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [1:0]        op_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    output logic              ack_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic [LINE_W-1:0] data_o,
    output logic              victim_valid_o,
    output logic              victim_dirty_o,
    output logic [TAG_W-1:0]  victim_tag_o,
    output logic [LINE_W-1:0] victim_data_o,
    output logic              busy_o
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INV   = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAY_W-1:0]   age_q   [SETS][WAYS];
    logic [TAG_W-1:0]   tag_mem [SETS][WAYS];
    logic [LINE_W-1:0]  data_mem[SETS][WAYS];

    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   vict_way;
    logic [WAY_W-1:0]   acc_way;
    logic [WAY_W-1:0]   pivot;
    logic [WAY_W-1:0]   age_nxt [WAYS];

    logic               line_we, line_dirty, lru_we, sweep_we;
    logic               ack_d, hit_d, busy_d, vv_d, vd_d;
    logic [WAY_W-1:0]   way_d;
    logic [LINE_W-1:0]  data_d, vdata_d;
    logic [TAG_W-1:0]   vtag_d;

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit_vec = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[idx_i][w] && (tag_mem[idx_i][w] == tag_i);
        end
        hit = |hit_vec;
    end

    // Hit way, victim (lowest invalid way, else the oldest way) and LRU update
    always_comb begin
        hit_way  = '0;
        vict_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (age_q[idx_i][w] == WAY_W'(WAYS - 1)) vict_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_i][w]) vict_way = WAY_W'(w);
        end
        acc_way = hit ? hit_way : vict_way;
        pivot   = age_q[idx_i][acc_way];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == acc_way) begin
                age_nxt[w] = '0;
            end else if (age_q[idx_i][w] < pivot) begin
                age_nxt[w] = age_q[idx_i][w] + WAY_W'(1);
            end else begin
                age_nxt[w] = age_q[idx_i][w];
            end
        end
    end

    // Request decode, sweep sequencing and next output values
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        ack_d       = 1'b0;
        hit_d       = hit_o;
        way_d       = way_o;
        data_d      = data_o;
        busy_d      = busy_o;
        vv_d        = victim_valid_o;
        vd_d        = victim_dirty_o;
        vtag_d      = victim_tag_o;
        vdata_d     = victim_data_o;
        line_we     = 1'b0;
        line_dirty  = 1'b0;
        lru_we      = 1'b0;
        sweep_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (op_i == OP_INV) begin
                        state_d     = ST_SWEEP;
                        sweep_idx_d = '0;
                        busy_d      = 1'b1;
                    end else begin
                        ack_d   = 1'b1;
                        hit_d   = hit;
                        way_d   = acc_way;
                        vv_d    = valid_q[idx_i][vict_way];
                        vd_d    = dirty_q[idx_i][vict_way];
                        vtag_d  = tag_mem[idx_i][vict_way];
                        vdata_d = data_mem[idx_i][vict_way];
                        case (op_i)
                            OP_READ: begin
                                if (hit) begin
                                    data_d = data_mem[idx_i][hit_way];
                                    lru_we = 1'b1;
                                end
                            end
                            OP_WRITE: begin
                                if (hit) begin
                                    data_d     = data_i;
                                    line_we    = 1'b1;
                                    line_dirty = 1'b1;
                                    lru_we     = 1'b1;
                                end
                            end
                            default: begin
                                data_d     = data_i;
                                line_we    = 1'b1;
                                line_dirty = dirty_i;
                                lru_we     = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_SWEEP: begin
                sweep_we    = 1'b1;
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
                if (sweep_idx_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    hit_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Line state: valid/dirty/age are reset; the sweep restores one set per cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (sweep_we) begin
            valid_q[sweep_idx_q] <= '0;
            dirty_q[sweep_idx_q] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                age_q[sweep_idx_q][w] <= WAY_W'(w);
            end
        end else begin
            if (line_we) begin
                valid_q[idx_i][acc_way] <= 1'b1;
                dirty_q[idx_i][acc_way] <= line_dirty;
            end
            if (lru_we) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[idx_i][w] <= age_nxt[w];
                end
            end
        end
    end

    // Tag and data storage carry no reset
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_mem[idx_i][acc_way]  <= tag_i;
            data_mem[idx_i][acc_way] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o          <= 1'b0;
            hit_o          <= 1'b0;
            way_o          <= '0;
            data_o         <= '0;
            busy_o         <= 1'b0;
            victim_valid_o <= 1'b0;
            victim_dirty_o <= 1'b0;
            victim_tag_o   <= '0;
            victim_data_o  <= '0;
        end else begin
            ack_o          <= ack_d;
            hit_o          <= hit_d;
            way_o          <= way_d;
            data_o         <= data_d;
            busy_o         <= busy_d;
            victim_valid_o <= vv_d;
            victim_dirty_o <= vd_d;
            victim_tag_o   <= vtag_d;
            victim_data_o  <= vdata_d;
        end
    end

endmodule
